// File: rtl/wordle_scorer.sv
// Sequential Wordle scorer: five green passes then five yellow passes, one letter per cycle.
// Optional guess-letter range check enabled by defining WORDLE_SCORER_CHARCHECK_EN.
module wordle_scorer #(
  parameter int unsigned CW = 8
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [5*CW-1:0] guess,
  input  logic [5*CW-1:0] target,
  output logic          busy,
  output logic          done,
  output logic [9:0]    colors,
  output logic          win
`ifdef WORDLE_SCORER_CHARCHECK_EN
  ,
  output logic          invalid
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StGreen,
    StYellow,
    StDone
  } state_e;

  state_e          state_q;
  logic [2:0]      idx_q;
  logic [5*CW-1:0] guess_q;
  logic [5*CW-1:0] target_q;
  logic [4:0]      green_q;
  logic [4:0]      yellow_q;
  logic [4:0]      used_q;

  logic [4:0]      sel;
  logic [CW-1:0]   cur_guess;
  logic [CW-1:0]   cur_target;
  logic            match_found;
  logic [2:0]      match_idx;
  logic [9:0]      colors_next;

  // Bit k of the position vectors is letter k+1, i.e. word slice (4-k)*CW.
  function automatic logic [CW-1:0] letter_at(input logic [5*CW-1:0] word,
                                              input logic [2:0]      k);
    letter_at = '0;
    for (int i = 0; i < 5; i++) begin
      if (k == 3'(i)) letter_at = word[(4-i)*CW +: CW];
    end
  endfunction

`ifdef WORDLE_SCORER_CHARCHECK_EN
  logic bad_q;
  logic bad_chars;

  always_comb begin
    bad_chars = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (guess[(4-i)*CW +: CW] < CW'('h41) || guess[(4-i)*CW +: CW] > CW'('h5A)) begin
        bad_chars = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel        = 5'b00001 << idx_q;
    cur_guess  = letter_at(guess_q, idx_q);
    cur_target = letter_at(target_q, idx_q);
    // Descending scan so the lowest unconsumed matching position wins.
    match_found = 1'b0;
    match_idx   = 3'd0;
    for (int j = 4; j >= 0; j--) begin
      if (!used_q[j] && letter_at(target_q, 3'(j)) == cur_guess) begin
        match_found = 1'b1;
        match_idx   = 3'(j);
      end
    end
    colors_next = '0;
    for (int k = 0; k < 5; k++) begin
      if (green_q[k]) begin
        colors_next[9-2*k -: 2] = 2'b10;
      end else if (yellow_q[k]) begin
        colors_next[9-2*k -: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      guess_q  <= '0;
      target_q <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      used_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      colors   <= '0;
      win      <= 1'b0;
`ifdef WORDLE_SCORER_CHARCHECK_EN
      bad_q    <= 1'b0;
      invalid  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            guess_q  <= guess;
            target_q <= target;
            green_q  <= '0;
            yellow_q <= '0;
            used_q   <= '0;
            idx_q    <= '0;
            busy     <= 1'b1;
`ifdef WORDLE_SCORER_CHARCHECK_EN
            bad_q    <= bad_chars;
            state_q  <= bad_chars ? StDone : StGreen;
`else
            state_q  <= StGreen;
`endif
          end
        end
        StGreen: begin
          if (cur_guess == cur_target) begin
            green_q <= green_q | sel;
            used_q  <= used_q | sel;
          end
          if (idx_q == 3'd4) begin
            idx_q   <= '0;
            state_q <= StYellow;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StYellow: begin
          if (((green_q & sel) == '0) && match_found) begin
            yellow_q <= yellow_q | sel;
            used_q   <= used_q | (5'b00001 << match_idx);
          end
          if (idx_q == 3'd4) begin
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StDone: begin
          done    <= 1'b1;
          colors  <= colors_next;
          win     <= (colors_next == 10'b1010101010);
          busy    <= 1'b0;
          state_q <= StIdle;
`ifdef WORDLE_SCORER_CHARCHECK_EN
          invalid <= bad_q;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_scorer.sv
// Randomized self-checking bench for wordle_scorer against a letter-count reference model.
module tb_wordle_scorer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [39:0] guess;
  logic [39:0] target;
  logic        busy;
  logic        done;
  logic [9:0]  colors;
  logic        win;
`ifdef WORDLE_SCORER_CHARCHECK_EN
  logic        invalid;
`endif

  int total;
  int bad;

  wordle_scorer #(.CW(8)) dut (
    .Clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .guess  (guess),
    .target (target),
    .busy   (busy),
    .done   (done),
    .colors (colors),
`ifdef WORDLE_SCORER_CHARCHECK_EN
    .invalid(invalid),
`endif
    .win    (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Greens first, then unmatched target letters are handed out left to right by count.
  function automatic logic [9:0] model(input logic [39:0] g, input logic [39:0] t);
    logic [7:0]  gl[5];
    logic [7:0]  tl[5];
    int          cnt[256];
    logic [9:0]  c;
    c = '0;
    for (int i = 0; i < 256; i++) cnt[i] = 0;
    for (int i = 0; i < 5; i++) begin
      gl[i] = g[(4-i)*8 +: 8];
      tl[i] = t[(4-i)*8 +: 8];
    end
    for (int i = 0; i < 5; i++) begin
      if (gl[i] == tl[i]) c[9-2*i -: 2] = 2'b10;
      else cnt[tl[i]]++;
    end
    for (int i = 0; i < 5; i++) begin
      if (gl[i] != tl[i] && cnt[gl[i]] > 0) begin
        c[9-2*i -: 2] = 2'b01;
        cnt[gl[i]]--;
      end
    end
    return c;
  endfunction

  task automatic score(input logic [39:0] g, input logic [39:0] t, input bit disturb,
                       input string tag);
    logic [9:0] exp;
    int n;
    int pulses;
    int first;
    exp    = model(g, t);
    guess  = g;
    target = t;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    pulses = 0;
    first = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 3) begin
        start  = 1'b1;
        guess  = "ZZZZZ";
        target = "YYYYY";
      end
      if (disturb && n == 4) start = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = n;
          check_val({tag, "_colors"}, 32'(colors), 32'(exp));
          check_val({tag, "_win"}, 32'(win), 32'(exp == 10'h2AA));
`ifdef WORDLE_SCORER_CHARCHECK_EN
          check_val({tag, "_invalid"}, 32'(invalid), 32'd0);
`endif
        end
      end
    end
    check_val({tag, "_latency"}, 32'(first), 32'd11);
    check_val({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_val({tag, "_hold"}, 32'(colors), 32'(exp));
  endtask

  function automatic logic [39:0] rand_word();
    logic [39:0] w;
    for (int i = 0; i < 5; i++) w[i*8 +: 8] = 8'($urandom_range(65, 69));
    return w;
  endfunction

  initial begin
    int n;
    int pulses;
    logic [39:0] w;
    total   = 0;
    bad     = 0;
    start   = 1'b0;
    guess   = '0;
    target  = '0;
    reset_n = 1'b0;
    #23;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_colors", 32'(colors), 32'd0);
    check_val("rst_win", 32'(win), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    score("CRANE", "CRANE", 1'b0, "crane");
    score("EERIE", "THERE", 1'b0, "eerie");
    check_val("eerie_exact", 32'(colors), 32'(10'b0100010010));
    score("NACER", "CRANE", 1'b0, "nacer");
    check_val("nacer_exact", 32'(colors), 32'(10'h155));
    score("EERIE", "THERE", 1'b1, "midop");

    // Abort in YELLOW: outputs clear at once and no done follows.
    guess  = "NACER";
    target = "CRANE";
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_colors", 32'(colors), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check_val("abort_nodone", 32'(pulses), 32'd0);
    score("CRANE", "CRANE", 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      w = rand_word();
      score(w, ($urandom_range(0, 4) == 0) ? w : rand_word(), 1'b0, $sformatf("rnd%0d", i));
    end

`ifdef WORDLE_SCORER_CHARCHECK_EN
    guess  = "CR4NE";
    target = "CRANE";
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (n < 20 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("inv_latency", 32'(n), 32'd1);
    check_val("inv_flag", 32'(invalid), 32'd1);
    check_val("inv_colors", 32'(colors), 32'd0);
    check_val("inv_win", 32'(win), 32'd0);
    score("CRANE", "CRANE", 1'b0, "valid_again");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wordle_scorer.md
WORDLE_SCORER -- requirements
Module: wordle_scorer

Interface
REQ-001 Parameter: CW, 8, character width in bits (ASCII upper-case letters).
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to score the current guess.
REQ-005 guess  input  5*CW  submitted word; guess[5*CW-1 -: CW] is letter 1, guess[CW-1:0] is letter 5.
REQ-006 target  input  5*CW  secret word, same letter ordering as guess.
REQ-007 busy  output  1  high while a scoring operation is in progress.
REQ-008 done  output  1  one-cycle pulse; colors and win are valid from this cycle.
REQ-009 colors  output  10  two bits per letter (colors[9:8] is letter 1): 00 gray, 01 yellow, 10 green; 11 never driven.
REQ-010 win  output  1  high when all five letters are green.

Function
REQ-011 States SHALL be IDLE, GREEN, YELLOW and DONE.
REQ-012 In IDLE, start=1 SHALL capture guess and target into internal registers, clear the working colors and consumed flags, and move to GREEN.
REQ-013 GREEN SHALL last exactly 5 cycles, one position per cycle (1 to 5); equal letters at a position SHALL set that position green and mark that target position consumed.
REQ-014 YELLOW SHALL last exactly 5 cycles, one guess position per cycle (1 to 5); skip positions already green.
REQ-015 In YELLOW, a non-green guess letter matching an unconsumed target position SHALL become yellow and consume the lowest-index match; with no match it SHALL stay gray.
REQ-016 DONE SHALL last 1 cycle: assert done, update colors and win, then return to IDLE.
REQ-017 Latency: start sampled at edge N; done SHALL be high in the cycle after edge N+11.
REQ-018 busy SHALL be high in GREEN, YELLOW and DONE, and low in IDLE.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 Changes on guess or target after capture SHALL NOT affect the result in progress.
REQ-021 colors and win SHALL hold their last values until the next DONE.
REQ-022 Duplicate letters SHALL be scored so that no target position is credited more than once, with green taking priority over yellow.
REQ-023 win SHALL equal (colors == 10'b1010101010) and SHALL be updated only in DONE.

Reset
REQ-024 reset_n=0 SHALL force IDLE with busy=0, done=0, colors=0, win=0, and all internal registers cleared, regardless of Clk.
REQ-025 Reset during GREEN or YELLOW SHALL abort the operation, and done SHALL NOT pulse for the aborted request.
REQ-026 After reset_n rises, the first start accepted SHALL behave as in REQ-012.

Configuration
REQ-027 Macro WORDLE_SCORER_CHARCHECK_EN: when defined, REQ-028 and REQ-029 apply; when undefined, no character checking is done and scoring is purely by equality.
REQ-028 The block SHALL add an output invalid (1 bit); at start it SHALL check every captured guess letter is in the range 8'h41 to 8'h5A.
REQ-029 On a failed check, invalid SHALL be set, the FSM SHALL skip GREEN and YELLOW and go straight to DONE (done 1 cycle after the start edge), and colors and win SHALL both be 0.

Verification
REQ-030 target "CRANE", guess "CRANE", start pulse -> done exactly 11 cycles later, colors=10'h2AA, win=1.
REQ-031 target "THERE", guess "EERIE" -> colors=10'b0100010010 (Y,gray,Y,gray,G), win=0.
REQ-032 target "CRANE", guess "NACER" -> all yellow: colors=10'h155, win=0.
REQ-033 start pulse at cycle 3 of GREEN, and guess changed mid-operation -> ignored; a single done pulse with the originally captured result.
REQ-034 reset_n low during YELLOW -> busy=0, colors=0 immediately; no done pulse.
REQ-035 With WORDLE_SCORER_CHARCHECK_EN defined, guess "CR4NE" -> invalid=1, done 1 cycle after start, colors=0.
